// File: rtl/srm_core_if.sv
// Bus between the SRM core and its controller: start/load handshake, instruction word,
// result register and status outputs.
interface srm_core_if #(
    parameter int unsigned DATA_W = 16
);
    logic              s;
    logic              load;
    logic [15:0]       in;
    logic [DATA_W-1:0] out;
    logic              N;
    logic              V;
    logic              Z;
    logic              w;
    logic              err;

    modport master (
        output s, load, in,
        input  out, N, V, Z, w, err
    );

    modport slave (
        input  s, load, in,
        output out, N, V, Z, w, err
    );
endinterface

// File: rtl/srm_core.sv
// Simple register machine: eight-register file, one-bit shifter on B, MOV/ADD/CMP/AND/MVN,
// executed by a multi-cycle FSM that idles in WAIT.
module srm_core #(
    parameter int unsigned DATA_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    srm_core_if.slave  bus
);
    localparam int unsigned IW   = 16;
    localparam int unsigned NREG = 8;
    localparam int unsigned MSB  = DATA_W - 1;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_DECODE,
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_WR_IMM,
        ST_WR_REG
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IW-1:0]     ir_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] c_q;
    logic [DATA_W-1:0] rf_q [NREG];
    logic              n_q;
    logic              v_q;
    logic              z_q;
    logic              err_q;
    logic              w_q;

    // Instruction fields
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] shift;
    logic [2:0] rm;
    logic [DATA_W-1:0] imm_sx;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign shift  = ir_q[4:3];
    assign rm     = ir_q[2:0];
    assign imm_sx = DATA_W'($signed(ir_q[7:0]));

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_add;
    logic is_cmp;
    logic is_and;
    logic is_mvn;
    logic is_undef;

    assign is_mov_imm = ({opcode, op} == 5'b110_10);
    assign is_mov_reg = ({opcode, op} == 5'b110_00);
    assign is_add     = ({opcode, op} == 5'b101_00);
    assign is_cmp     = ({opcode, op} == 5'b101_01);
    assign is_and     = ({opcode, op} == 5'b101_10);
    assign is_mvn     = ({opcode, op} == 5'b101_11);
    assign is_undef   = ~(is_mov_imm | is_mov_reg | is_add | is_cmp | is_and | is_mvn);

    // Shifter on B and ALU
    logic [DATA_W-1:0] sh_b;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] alu_res;
    logic              cmp_v;

    always_comb begin
        sh_b = b_q;
        unique case (shift)
            2'b00:   sh_b = b_q;
            2'b01:   sh_b = {b_q[MSB-1:0], 1'b0};
            2'b10:   sh_b = {1'b0, b_q[MSB:1]};
            default: sh_b = {b_q[MSB], b_q[MSB:1]};
        endcase
    end

    assign diff  = a_q - sh_b;
    assign cmp_v = (a_q[MSB] ^ sh_b[MSB]) & (diff[MSB] ^ a_q[MSB]);

    always_comb begin
        alu_res = sh_b;
        if (is_add)      alu_res = a_q + sh_b;
        else if (is_and) alu_res = a_q & sh_b;
        else if (is_mvn) alu_res = ~sh_b;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT:   if (bus.s) state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_mov_imm)                  state_d = ST_WR_IMM;
                else if (is_mov_reg || is_mvn)   state_d = ST_GET_B;
                else if (is_add || is_and || is_cmp) state_d = ST_GET_A;
                else                             state_d = ST_WAIT;
            end
            ST_GET_A:  state_d = ST_GET_B;
            ST_GET_B:  state_d = ST_EXEC;
            ST_EXEC:   state_d = is_cmp ? ST_WAIT : ST_WR_REG;
            ST_WR_IMM: state_d = ST_WAIT;
            ST_WR_REG: state_d = ST_WAIT;
            default:   state_d = ST_WAIT;
        endcase
    end

    // Per-state datapath strobes
    logic              ir_we;
    logic              a_we;
    logic              b_we;
    logic              c_we;
    logic              flags_we;
    logic              rf_we;
    logic [2:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              err_set;
    logic              err_clr;

    always_comb begin
        ir_we    = 1'b0;
        a_we     = 1'b0;
        b_we     = 1'b0;
        c_we     = 1'b0;
        flags_we = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = rn;
        rf_wdata = imm_sx;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                ir_we   = bus.load;
                err_clr = bus.s;
            end
            ST_DECODE: err_set = is_undef;
            ST_GET_A:  a_we = 1'b1;
            ST_GET_B:  b_we = 1'b1;
            ST_EXEC: begin
                c_we     = ~is_cmp;
                flags_we = is_cmp;
            end
            ST_WR_IMM: rf_we = 1'b1;
            ST_WR_REG: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                rf_wdata = c_q;
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset wins over any in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
            w_q     <= 1'b1;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= (state_d == ST_WAIT);
            if (ir_we) ir_q <= bus.in;
            if (a_we)  a_q  <= rf_q[rn];
            if (b_we)  b_q  <= rf_q[rm];
            if (c_we)  c_q  <= alu_res;
            if (flags_we) begin
                n_q <= diff[MSB];
                v_q <= cmp_v;
                z_q <= (diff == '0);
            end
            if (rf_we) rf_q[rf_waddr] <= rf_wdata;
            if (err_set)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
        end
    end

    assign bus.out = c_q;
    assign bus.N   = n_q;
    assign bus.V   = v_q;
    assign bus.Z   = z_q;
    assign bus.w   = w_q;
    assign bus.err = err_q;
endmodule
